// File: rtl/gl_fb_pkg.sv
// Shared definitions for the framebuffer write path: pixel-word field layout,
// arbiter state encoding and a counter-width helper.
package gl_fb_pkg;

  localparam int DATA_W_DEF = 96;

  // Pixel word layout: {x, y, rgba}, each field 32 bits wide.
  localparam int X_MSB    = 95;
  localparam int X_LSB    = 64;
  localparam int Y_MSB    = 63;
  localparam int Y_LSB    = 32;
  localparam int RGBA_MSB = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_clear_gen.sv
// Row-major raster-scan coordinate generator used by the screen-clear engine.
// Synchronous zero has priority over advance; last_o flags (H_RES-1, V_RES-1).
module fb_clear_gen
  import gl_fb_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = cnt_w(H_RES),
  parameter int YW    = cnt_w(V_RES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          zero_i,
  input  logic          adv_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end  = (x_q == XW'(H_RES - 1));
  assign y_end  = (y_q == YW'(V_RES - 1));
  assign last_o = x_end & y_end;
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (zero_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_end) begin
        x_d = '0;
        // Wrapping y on the final pixel leaves the scan ready for the next frame.
        y_d = y_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates the framebuffer FIFO write port between the rasterizer and the
// screen-clear engine. Optional scissor drop filter: define FB_SCISSOR_EN.
module fb_write_arbiter
  import gl_fb_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic [31:0]       clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              ras_wr_en,
  input  logic [DATA_W-1:0] ras_wr_data,
  output logic              ras_full,
  input  logic              fb_afull,
  output logic              fb_wr_en,
  output logic [DATA_W-1:0] fb_wr_data,
`ifdef FB_SCISSOR_EN
  output logic [31:0]       drop_cnt,
`endif
  output logic [1:0]        dbg_state
);

  localparam int XW = cnt_w(H_RES);
  localparam int YW = cnt_w(V_RES);

  fb_state_e         state_q, state_d;
  logic              pending_q, pending_d;
  logic [31:0]       color_q, color_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              scan_adv, scan_zero, scan_last;
  logic [XW-1:0]     scan_x;
  logic [YW-1:0]     scan_y;

  // Handshake: a rasterizer pixel transfers on any cycle with ras_wr_en high and
  // ras_full low; the rasterizer keeps ras_wr_en low while ras_full is high.
  // Downstream, fb_afull guarantees two free entries, covering the one-cycle
  // registered write latency.
  assign ras_full   = fb_afull | (state_q != IDLE) | pending_q;
  assign fb_wr_en   = wr_en_q;
  assign fb_wr_data = wr_data_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign dbg_state  = state_q;
  assign scan_zero  = (state_q != CLEAR);

  fb_clear_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .XW    (XW),
    .YW    (YW)
  ) u_clear_gen (
    .clk    (clk),
    .rst    (rst),
    .zero_i (scan_zero),
    .adv_i  (scan_adv),
    .x_o    (scan_x),
    .y_o    (scan_y),
    .last_o (scan_last)
  );

`ifdef FB_SCISSOR_EN
  localparam logic [31:0] H_LIM = 32'(H_RES);
  localparam logic [31:0] V_LIM = 32'(V_RES);

  logic [31:0] drop_q, drop_d;
  logic        in_bounds;

  // Unsigned compare makes negative coordinates fall outside the screen.
  assign in_bounds = (ras_wr_data[X_MSB:X_LSB] < H_LIM) &&
                     (ras_wr_data[Y_MSB:Y_LSB] < V_LIM);
  assign drop_cnt  = drop_q;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | clear_req;
    color_d   = color_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    scan_adv  = 1'b0;
`ifdef FB_SCISSOR_EN
    drop_d    = drop_q;
`endif

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = CLEAR;
          accept  = 1'b1;
        end else if (ras_wr_en && !ras_full) begin
`ifdef FB_SCISSOR_EN
          if (in_bounds) begin
            wr_en_d   = 1'b1;
            wr_data_d = ras_wr_data;
          end else if (drop_q != 32'hFFFF_FFFF) begin
            drop_d = drop_q + 32'd1;
          end
`else
          wr_en_d   = 1'b1;
          wr_data_d = ras_wr_data;
`endif
        end
      end

      CLEAR: begin
        if (!fb_afull) begin
          wr_en_d                    = 1'b1;
          wr_data_d                  = '0;
          wr_data_d[X_MSB:X_LSB]     = 32'(scan_x);
          wr_data_d[Y_MSB:Y_LSB]     = 32'(scan_y);
          wr_data_d[RGBA_MSB:0]      = color_q;
          scan_adv                   = 1'b1;
          if (scan_last) state_d = DONE;
        end
      end

      DONE: begin
        done_d = 1'b1;
        if (pending_q) begin
          state_d = CLEAR;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A request arriving on the accept cycle itself queues the next clear.
    if (accept) begin
      pending_d = clear_req;
      color_d   = clear_color;
    end

    busy_d = pending_d | (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      color_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      color_q   <= color_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef FB_SCISSOR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter on a 4x2 screen: pass-through, clears,
// backpressure, queued clears, mid-clear reset and (when enabled) scissor drops.
module tb_fb_write_arbiter;

  localparam int H = 4;
  localparam int V = 2;
  localparam int W = 96;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear_req = 1'b0;
  logic [31:0]  clear_color = '0;
  logic         clear_busy, clear_done;
  logic         ras_wr_en = 1'b0;
  logic [W-1:0] ras_wr_data = '0;
  logic         ras_full;
  logic         fb_afull = 1'b0;
  logic         fb_wr_en;
  logic [W-1:0] fb_wr_data;
  logic [1:0]   dbg_state;
`ifdef FB_SCISSOR_EN
  logic [31:0]  drop_cnt;
`endif

  fb_write_arbiter #(.H_RES(H), .V_RES(V), .DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .ras_wr_en   (ras_wr_en),
    .ras_wr_data (ras_wr_data),
    .ras_full    (ras_full),
    .fb_afull    (fb_afull),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_data  (fb_wr_data),
`ifdef FB_SCISSOR_EN
    .drop_cnt    (drop_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           total = 0;
  int           bad = 0;
  int           done_seen = 0;
  int           done_exp = 0;
  int           wr_seen = 0;
  logic         prev_last = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pix(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] c);
    return {x, y, c};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (clear_done) begin
        done_seen++;
        check("done_after_last_write", prev_last, 1'b1);
      end
      if (fb_wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0h expected none", fb_wr_data);
        end else begin
          check("fb_wr_data", fb_wr_data, exp_q.pop_front());
        end
      end
      prev_last = fb_wr_en && (fb_wr_data[95:64] == 32'(H - 1)) &&
                  (fb_wr_data[63:32] == 32'(V - 1));
    end else begin
      prev_last = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [W-1:0] w, input logic fwd);
    check("ras_full_before_pixel", ras_full, 1'b0);
    ras_wr_en   = 1'b1;
    ras_wr_data = w;
    if (fwd) exp_q.push_back(w);
    @(negedge clk);
    ras_wr_en = 1'b0;
    check("pixel_latency", fb_wr_en, fwd);
    check("ras_full_after_pixel", ras_full, 1'b0);
  endtask

  task automatic pulse_clear(input logic [31:0] color);
    clear_color = color;
    clear_req   = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic push_clear(input logic [31:0] color, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pix(32'(i % H), 32'(i / H), color));
  endtask

  task automatic wait_done(input logic check_full);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (clear_done) got = 1'b1;
      else if (check_full) check("ras_full_during_clear", ras_full, 1'b1);
    end
    check("clear_done_timeout", got, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base;
    int cnt;
    logic hit;

    #12;
    check("rst_fb_wr_en", fb_wr_en, 1'b0);
    check("rst_fb_wr_data", fb_wr_data, '0);
    check("rst_clear_busy", clear_busy, 1'b0);
    check("rst_clear_done", clear_done, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: pass-through
    send_pixel(pix(32'd3, 32'd1, 32'hFF00FF00), 1'b1);
    send_pixel(pix(32'd0, 32'd0, 32'h01020304), 1'b1);

    // 2: full clear
    pulse_clear(32'h11223344);
    push_clear(32'h11223344, 8);
    check("busy_after_req", clear_busy, 1'b1);
    wait_done(1'b1);
    done_exp++;
    @(negedge clk);
    check("clear2_all_writes", exp_q.size(), 0);
    check("clear2_busy_low", clear_busy, 1'b0);
    check("clear2_ras_full_low", ras_full, 1'b0);

    // 3: backpressure mid-clear
    pulse_clear(32'hA5A5A5A5);
    push_clear(32'hA5A5A5A5, 8);
    base = wr_seen;
    hit  = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (wr_seen >= base + 3) hit = 1'b1;
    end
    check("bp_reach_write3", hit, 1'b1);
    fb_afull = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_no_write", fb_wr_en, 1'b0);
    end
    fb_afull = 1'b0;
    wait_done(1'b1);
    done_exp++;
    @(negedge clk);
    check("bp_all_writes", exp_q.size(), 0);

    // 4: two requests during a clear -> exactly one queued clear, new color
    pulse_clear(32'hAAAA0001);
    @(negedge clk);
    clear_color = 32'hBBBB0002;
    push_clear(32'hAAAA0001, 8);
    push_clear(32'hBBBB0002, 8);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_done(1'b1);
    done_exp++;
    wait_done(1'b1);
    done_exp++;
    @(negedge clk);
    check("queued_all_writes", exp_q.size(), 0);
    check("queued_busy_low", clear_busy, 1'b0);

    // pixel and clear request on the same cycle: pixel goes first
    ras_wr_en   = 1'b1;
    ras_wr_data = pix(32'd2, 32'd1, 32'hCAFEF00D);
    clear_color = 32'h0000BEEF;
    clear_req   = 1'b1;
    exp_q.push_back(pix(32'd2, 32'd1, 32'hCAFEF00D));
    push_clear(32'h0000BEEF, 8);
    @(negedge clk);
    ras_wr_en = 1'b0;
    clear_req = 1'b0;
    check("same_cycle_pixel_first", fb_wr_en, 1'b1);
    wait_done(1'b1);
    done_exp++;
    @(negedge clk);
    check("same_cycle_all_writes", exp_q.size(), 0);

    // 5: reset during a clear
    pulse_clear(32'h55AA55AA);
    push_clear(32'h55AA55AA, 3);
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 3; i++) begin
      @(negedge clk);
      if (fb_wr_en) cnt++;
    end
    check("abort_reach_write3", cnt, 3);
    #2 rst = 1'b0;
    #1;
    check("abort_fb_wr_en", fb_wr_en, 1'b0);
    check("abort_fb_wr_data", fb_wr_data, '0);
    check("abort_clear_busy", clear_busy, 1'b0);
    check("abort_clear_done", clear_done, 1'b0);
    check("abort_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", clear_done, 1'b0);
    end
    check("abort_state_idle", dbg_state, 2'd0);
    check("abort_busy_low", clear_busy, 1'b0);
    check("abort_queue_drained", exp_q.size(), 0);

`ifdef FB_SCISSOR_EN
    // 6: scissor drops
    send_pixel(pix(32'd4, 32'd0, 32'h12345678), 1'b0);
    send_pixel(pix(32'hFFFFFFFF, 32'd1, 32'h12345678), 1'b0);
    check("scissor_drop_cnt", drop_cnt, 32'd2);
    send_pixel(pix(32'd3, 32'd0, 32'h12345678), 1'b1);
    check("scissor_drop_cnt_hold", drop_cnt, 32'd2);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_count", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
